// File: rtl/bram_sdp.sv
// ---------------------------------------------------------------------------
// bram_sdp
//   Simple-dual-port block RAM: one byte-enabled write port and one
//   independent read port. The read pipeline has an optional output register.
//   A read that hits the word written in the same cycle returns a per-lane
//   merge of new and old data. After reset an optional sequencer writes zero
//   to every word and holds off both ports while it runs.
// ---------------------------------------------------------------------------
module bram_sdp #(
    parameter int ADDR_      = 8,   // address width, depth = 2**ADDR_
    parameter int DATA_      = 32,  // word width
    parameter int BYTE_      = 8,   // bits per byte-enable lane
    parameter int OUT_REG    = 0,   // 1 = read latency 2, 0 = latency 1
    parameter int CLEAR_INIT = 1    // 1 = zero all words after reset
) (
    input  logic                     clk,
    input  logic                     aclr_n,
    output logic                     busy,
    input  logic                     wr_en,
    input  logic [ADDR_-1:0]         wr_addr,
    input  logic [DATA_/BYTE_-1:0]   wr_be,
    input  logic [DATA_-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [ADDR_-1:0]         rd_addr,
    output logic                     rd_valid,
    output logic [DATA_-1:0]         rd_data
);

    localparam int NBE   = DATA_ / BYTE_;
    localparam int DEPTH = 2 ** ADDR_;

    // Reject geometries the lane slicing and addressing cannot express.
    generate
        if ((DATA_ % BYTE_) != 0 || ADDR_ == 0) begin : g_bad_params
            $error("bram_sdp: DATA_ must be a multiple of BYTE_ and ADDR_ must be non-zero");
        end
    endgenerate

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_INIT != 0) ? S_CLEAR : S_RUN;

    state_t             state_q, state_d;
    logic [ADDR_-1:0]   clr_cnt_q, clr_cnt_d;

    logic               run;
    logic               wr_fire;
    logic               rd_fire;
    logic               rd_hit;

    logic [DATA_-1:0]   mem [DEPTH];

    logic [DATA_-1:0]   ram_q;       // raw registered array read
    logic               v1_q;        // a read result is present after stage 1
    logic               seen_q;      // ram_q holds a real read since reset
    logic [NBE-1:0]     fwd_be_q;    // lanes to take from the colliding write
    logic [DATA_-1:0]   fwd_data_q;  // write data captured with the read
    logic [DATA_-1:0]   merged;      // stage-1 result after lane merge

    // Port requests only take effect once the clear sequence has finished.
    assign run     = (state_q == S_RUN);
    assign busy    = ~run;
    assign wr_fire = run & wr_en;
    assign rd_fire = run & rd_en;
    assign rd_hit  = wr_fire && (wr_addr == rd_addr);

    // State register for the clear sequencer.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of the order the blocks execute in.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q   <= RESET_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state logic: walk every address once, then hand over to RUN.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_'(1);
                if (&clr_cnt_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                clr_cnt_d = '0;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Array write: zero fill while clearing, byte-lane write while running.
    // NOTE: the storage array has no reset; a reset term on it would stop it
    // from mapping to block RAM. Zeroing is the sequencer's job instead.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NBE; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BYTE_ +: BYTE_] <= wr_data[i*BYTE_ +: BYTE_];
                end
            end
        end
    end

    // Registered array read; sees the old word when the write hits the same
    // address in this cycle, which the forwarding lanes below patch up.
    always_ff @(posedge clk) begin
        if (rd_fire) begin
            ram_q <= mem[rd_addr];
        end
    end

    // Stage-1 control: valid flag plus the lanes of a same-cycle write.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            v1_q       <= 1'b0;
            seen_q     <= 1'b0;
            fwd_be_q   <= '0;
            fwd_data_q <= '0;
        end else begin
            v1_q <= rd_fire;
            if (rd_fire) begin
                seen_q     <= 1'b1;
                fwd_be_q   <= rd_hit ? wr_be : '0;
                fwd_data_q <= wr_data;
            end
        end
    end

    // Lane merge: forwarded write lanes override the stale array word.
    always_comb begin
        merged = seen_q ? ram_q : '0;
        for (int i = 0; i < NBE; i++) begin
            if (fwd_be_q[i]) begin
                merged[i*BYTE_ +: BYTE_] = fwd_data_q[i*BYTE_ +: BYTE_];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             v2_q;
            logic [DATA_-1:0] rd_q;

            // Output register stage: latch the merged word on each result.
            always_ff @(posedge clk or negedge aclr_n) begin
                if (!aclr_n) begin
                    v2_q <= 1'b0;
                    rd_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) begin
                        rd_q <= merged;
                    end
                end
            end

            assign rd_valid = v2_q;
            assign rd_data  = rd_q;
        end else begin : g_no_out_reg
            // Stage-1 registers only load on a read, so merged already holds.
            assign rd_valid = v1_q;
            assign rd_data  = merged;
        end
    endgenerate

endmodule

// File: tb/tb_bram_sdp.sv
// ---------------------------------------------------------------------------
// tb_bram_sdp
//   Two instances (latency 1 and latency 2) share one stimulus stream.
//   The driver keeps a word-array model, pushes each expected read result
//   with its due cycle, and per-port monitors pop and compare on rd_valid.
// ---------------------------------------------------------------------------
module tb_bram_sdp;

    localparam int ADDR_ = 4;
    localparam int DATA_ = 32;
    localparam int BYTE_ = 8;
    localparam int NBE   = DATA_ / BYTE_;
    localparam int DEPTH = 2 ** ADDR_;

    typedef struct {
        logic [DATA_-1:0] data;
        int               cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              aclr_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_-1:0]  wr_addr = '0;
    logic [NBE-1:0]    wr_be = '0;
    logic [DATA_-1:0]  wr_data = '0;
    logic              rd_en = 1'b0;
    logic [ADDR_-1:0]  rd_addr = '0;
    logic              busy0, busy1, rv0, rv1;
    logic [DATA_-1:0]  rd0, rd1;

    exp_t              q0[$];
    exp_t              q1[$];
    logic [DATA_-1:0]  model [DEPTH];
    logic [DATA_-1:0]  last0 = '0;
    logic [DATA_-1:0]  last1 = '0;
    int                cyc = 0;
    int                clr_left = 0;
    int                n_checks = 0;
    int                n_pass = 0;
    bit                mon_en = 1'b0;

    always #5 clk = ~clk;

    // Cycle count of rising edges, read at falling edges.
    always @(posedge clk) cyc <= cyc + 1;

    bram_sdp #(.ADDR_(ADDR_), .DATA_(DATA_), .BYTE_(BYTE_), .OUT_REG(0), .CLEAR_INIT(1)) dut0 (
        .clk(clk), .aclr_n(aclr_n), .busy(busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv0), .rd_data(rd0)
    );

    bram_sdp #(.ADDR_(ADDR_), .DATA_(DATA_), .BYTE_(BYTE_), .OUT_REG(1), .CLEAR_INIT(1)) dut1 (
        .clk(clk), .aclr_n(aclr_n), .busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv1), .rd_data(rd1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    // Compare one port against the head of its expectation queue.
    task automatic mon_port(input int p, input logic v, input logic [DATA_-1:0] d);
        exp_t             e;
        bit               have;
        logic [DATA_-1:0] last;
        if (p == 0) begin
            have = (q0.size() != 0);
            last = last0;
            if (have) e = q0[0];
        end else begin
            have = (q1.size() != 0);
            last = last1;
            if (have) e = q1[0];
        end
        if (v) begin
            if (!have) begin
                check($sformatf("rd_valid_extra%0d", p), 32'(v), 32'd0);
            end else begin
                check($sformatf("rd_data%0d", p), d, e.data);
                check($sformatf("rd_latency%0d", p), cyc, e.cyc);
                if (p == 0) begin q0.delete(0); last0 = d; end
                else        begin q1.delete(0); last1 = d; end
            end
        end else begin
            check($sformatf("rd_hold%0d", p), d, last);
            if (have && e.cyc <= cyc) begin
                check($sformatf("rd_valid_missing%0d", p), 32'(v), 32'd1);
                if (p == 0) q0.delete(0);
                else        q1.delete(0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_port(0, rv0, rd0);
            mon_port(1, rv1, rd1);
        end
    end

    // One clock of stimulus; updates the reference model and expectations.
    task automatic step(input bit we, input logic [ADDR_-1:0] wa, input logic [NBE-1:0] be,
                        input logic [DATA_-1:0] wd, input bit re, input logic [ADDR_-1:0] ra);
        exp_t             e;
        logic [DATA_-1:0] word;
        @(negedge clk);
        wr_en   = we;
        wr_addr = wa;
        wr_be   = be;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        check("busy0", 32'(busy0), 32'(clr_left > 0));
        check("busy1", 32'(busy1), 32'(clr_left > 0));
        if (clr_left > 0) begin
            clr_left--;
        end else begin
            if (re) begin
                word = model[ra];
                if (we && wa == ra) begin
                    for (int i = 0; i < NBE; i++)
                        if (be[i]) word[i*BYTE_ +: BYTE_] = wd[i*BYTE_ +: BYTE_];
                end
                e.data = word;
                e.cyc  = cyc + 1;
                q0.push_back(e);
                e.cyc  = cyc + 2;
                q1.push_back(e);
            end
            if (we) begin
                for (int i = 0; i < NBE; i++)
                    if (be[i]) model[wa][i*BYTE_ +: BYTE_] = wd[i*BYTE_ +: BYTE_];
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic wr(input logic [ADDR_-1:0] a, input logic [NBE-1:0] be, input logic [DATA_-1:0] d);
        step(1'b1, a, be, d, 1'b0, '0);
    endtask

    task automatic rd(input logic [ADDR_-1:0] a);
        step(1'b0, '0, '0, '0, 1'b1, a);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        aclr_n = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        check("reset_busy0", 32'(busy0), 32'd1);
        check("reset_busy1", 32'(busy1), 32'd1);
        check("reset_valid0", 32'(rv0), 32'd0);
        check("reset_valid1", 32'(rv1), 32'd0);
        check("reset_data0", rd0, 32'd0);
        check("reset_data1", rd1, 32'd0);
        last0 = '0;
        last1 = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(posedge clk);
        #1;
        aclr_n   = 1'b1;
        clr_left = DEPTH;
        mon_en   = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, full clear, then every word reads back as zero.
        do_reset();
        idle(DEPTH + 1);
        for (int a = 0; a < DEPTH; a++) rd(ADDR_'(a));
        idle(3);

        // Full-word write followed by a read.
        wr(4'd3, 4'hF, 32'hDEADBEEF);
        rd(4'd3);
        idle(3);

        // Same-cycle read-during-write with partial lanes, then a plain read.
        wr(4'd5, 4'hF, 32'h11223344);
        step(1'b1, 4'd5, 4'b0101, 32'hAABBCCDD, 1'b1, 4'd5);
        rd(4'd5);
        idle(3);

        // Back-to-back reads after filling addresses 0..3.
        for (int a = 0; a < 4; a++) wr(ADDR_'(a), 4'hF, 32'hA0 + 32'(a));
        for (int a = 0; a < 4; a++) rd(ADDR_'(a));
        idle(3);

        // Write to a different address while reading the previous one.
        wr(4'd9, 4'hF, 32'h99990009);
        step(1'b1, 4'd10, 4'hF, 32'h1010AAAA, 1'b1, 4'd9);
        rd(4'd10);
        idle(3);

        // Zero-enable write is a no-op.
        wr(4'd3, 4'h0, 32'h12345678);
        rd(4'd3);
        idle(3);

        // Randomised traffic; half the reads collide with the write address.
        for (int n = 0; n < 400; n++) begin
            logic [ADDR_-1:0] wa, ra;
            wa = ADDR_'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 1) != 0) ? wa : ADDR_'($urandom_range(0, DEPTH - 1));
            step(1'($urandom_range(0, 1)), wa, NBE'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 1)), ra);
        end
        idle(3);

        // Fill memory, then interrupt the clear at address 7 and let it restart.
        for (int a = 0; a < DEPTH; a++) wr(ADDR_'(a), 4'hF, $urandom | 32'h1);
        idle(3);
        do_reset();
        for (int n = 0; n < 7; n++)
            step(1'b1, ADDR_'(n), 4'hF, 32'hFFFFFFFF, 1'b1, ADDR_'(n));
        do_reset();
        for (int n = 0; n < DEPTH; n++)
            step(1'($urandom_range(0, 1)), ADDR_'($urandom_range(0, DEPTH - 1)), 4'hF, $urandom,
                 1'($urandom_range(0, 1)), ADDR_'($urandom_range(0, DEPTH - 1)));
        idle(1);
        for (int a = 0; a < DEPTH; a++) rd(ADDR_'(a));
        idle(4);

        check("pending0", 32'(q0.size()), 32'd0);
        check("pending1", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
